rob: RTL
========

Name: rob

Overview:
- 16-entry reorder buffer that sits directly upstream of the register file.
- Allocates entries in program order at dispatch, captures results from the common data bus, and retires at most one entry per cycle in order.
- On retire it drives the register-file write port; on a branch mispredict it raises a flush with the redirect PC.
- Also serves combinational operand lookups by tag for the issue stage.

Parameters:
- ROB_S, 16, number of entries (power of two).
- ROB_ADD_W, 4, tag width, log2(ROB_S).
- REG_ADD_W, 5, architectural register index width.
- REG_DAT_W, 32, data width.
- ADDR_W, 32, PC width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when 0, all state holds.
- disp_en  in  1  dispatch request.
- disp_rd  in  REG_ADD_W  destination register; ignored for branches.
- disp_is_br  in  1  entry is a conditional branch.
- disp_pred  in  1  predicted taken.
- disp_pc  in  ADDR_W  instruction PC.
- disp_tag  out  ROB_ADD_W  tag that this cycle's dispatch receives (tail).
- full  out  1  count == ROB_S.
- cdb_en  in  1  result broadcast valid.
- cdb_tag  in  ROB_ADD_W  completing entry.
- cdb_val  in  REG_DAT_W  result value.
- cdb_taken  in  1  actual branch outcome.
- cdb_target  in  ADDR_W  branch target if taken.
- qry_tag  in  ROB_ADD_W  operand lookup tag.
- qry_rdy  out  1  entry result available.
- qry_val  out  REG_DAT_W  entry result.
- reg_we  out  1  register-file write strobe.
- reg_rd  out  REG_ADD_W  write index.
- reg_val  out  REG_DAT_W  write data.
- cmt_tag  out  ROB_ADD_W  tag of the retired entry, so the register file clears its rename.
- flush  out  1  mispredict flush pulse.
- flush_pc  out  ADDR_W  redirect PC.

Behaviour:
- Reset (synchronous, rst=1 at an edge): head=tail=count=0; all ready bits 0; reg_we=0, reg_rd=0, reg_val=0, cmt_tag=0, flush=0, flush_pc=0. Reset wins over rdy and over every other input.
- rdy=0: no state, pointer or output register changes. Downstream also consumes only on rdy=1 edges, so strobes held across a stall are seen exactly once.
- Storage: circular buffer; head and tail are ROB_ADD_W bits and wrap naturally from 15 to 0; count is ROB_ADD_W+1 bits.
- Dispatch (edge, disp_en && !full):
  - Write entry[tail] = {rd, is_br, pred, pc, ready=0}; tail++.
  - full is evaluated on the pre-edge count: a dispatch while full is dropped, even if a retire happens in the same cycle.
- Complete (edge, cdb_en): entry[cdb_tag].ready=1; store val, taken, target. A CDB write to an unallocated tag is illegal and need not be checked.
- Retire (edge, count>0 && entry[head].ready); one entry per edge.
  - Non-branch: reg_we=1 only if rd≠0; reg_rd=rd, reg_val=val, cmt_tag=head; head++.
  - Branch, correct prediction: reg_we=0, flush=0; head++.
  - Branch, taken≠pred: flush=1; flush_pc = taken ? target : pc+4 (mod 2^ADDR_W). The whole ROB clears in the same edge (head=tail=count=0, ready bits cleared); any dispatch and CDB write in that cycle are discarded.
- Strobe outputs (reg_we, flush) are registered: asserted for exactly one rdy=1 cycle after the retiring edge, then return to 0 unless another retire occurs.
- count update: +1 on dispatch, −1 on retire, unchanged when both occur; forced to 0 on flush.
- A CDB write to head in cycle t makes that entry retireable no earlier than the edge ending cycle t+1; there is no same-edge complete-and-retire.
- Query (combinational):
  - If cdb_en && cdb_tag==qry_tag: qry_rdy=1, qry_val=cdb_val (bypass).
  - Otherwise qry_rdy=entry[qry_tag].ready and qry_val=entry[qry_tag].val.

Decomposition:
- Shared header holds ROB_S, ROB_ADD_W, REG_ADD_W, REG_DAT_W, ADDR_W, and the entry field widths.
- No sub-module: the entry array and the pointer logic stay in one module.

Test Plan:
- Reset then dispatch 3 ALU ops (rd=1,2,3); CDB completes tags 2,0,1 with 0xA,0xB,0xC → retires in order: reg_rd 1,2,3 with vals 0xB,0xC,0xA, one per cycle.
- Dispatch 16 ops → full=1; a 17th disp_en causes no change to tail; complete and retire tag 0 → full=0 and disp_tag=0 (wrap).
- Branch at pc=0x100, pred=0, CDB taken=1, target=0x200, with 2 younger entries → flush=1 for one cycle, flush_pc=0x200, count=0; younger entries never write. Repeat with pred=1, taken=0 → flush_pc=0x104.
- rd=0 op completes with 0x55 → retires with reg_we=0, head advances.
- Hold rdy=0 for 5 cycles around a retire edge and a CDB pulse → no pointer movement; reg_we seen exactly once after rdy returns.
- qry_tag=5 while cdb_en, cdb_tag=5, cdb_val=0x77 → qry_rdy=1, qry_val=0x77 in the same cycle.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared widths and entry payload types for the reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_S     = 16;
  localparam int unsigned ROB_ADD_W = 4;
  localparam int unsigned REG_ADD_W = 5;
  localparam int unsigned REG_DAT_W = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned CNT_W     = ROB_ADD_W + 1;

  // Fields captured at dispatch
  typedef struct packed {
    logic [REG_ADD_W-1:0] rd;
    logic                 is_br;
    logic                 pred;
    logic [ADDR_W-1:0]    pc;
  } rob_info_t;

  // Fields captured from the common data bus
  typedef struct packed {
    logic [REG_DAT_W-1:0] val;
    logic                 taken;
    logic [ADDR_W-1:0]    target;
  } rob_res_t;

endpackage

// File: rtl/rob.sv
// 16-entry reorder buffer: in-order allocate, out-of-order complete, in-order
// retire into the register file, with mispredict flush and operand lookup.
module rob
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 disp_en,
  input  logic [REG_ADD_W-1:0] disp_rd,
  input  logic                 disp_is_br,
  input  logic                 disp_pred,
  input  logic [ADDR_W-1:0]    disp_pc,
  output logic [ROB_ADD_W-1:0] disp_tag,
  output logic                 full,
  input  logic                 cdb_en,
  input  logic [ROB_ADD_W-1:0] cdb_tag,
  input  logic [REG_DAT_W-1:0] cdb_val,
  input  logic                 cdb_taken,
  input  logic [ADDR_W-1:0]    cdb_target,
  input  logic [ROB_ADD_W-1:0] qry_tag,
  output logic                 qry_rdy,
  output logic [REG_DAT_W-1:0] qry_val,
  output logic                 reg_we,
  output logic [REG_ADD_W-1:0] reg_rd,
  output logic [REG_DAT_W-1:0] reg_val,
  output logic [ROB_ADD_W-1:0] cmt_tag,
  output logic                 flush,
  output logic [ADDR_W-1:0]    flush_pc
);

  logic [ROB_ADD_W-1:0] r_head;
  logic [ROB_ADD_W-1:0] r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [ROB_S-1:0]     r_ready;
  rob_info_t            r_info [ROB_S];
  rob_res_t             r_res  [ROB_S];

  logic                 r_reg_we;
  logic [REG_ADD_W-1:0] r_reg_rd;
  logic [REG_DAT_W-1:0] r_reg_val;
  logic [ROB_ADD_W-1:0] r_cmt_tag;
  logic                 r_flush;
  logic [ADDR_W-1:0]    r_flush_pc;

  rob_info_t            w_hinfo;
  rob_res_t             w_hres;
  logic                 w_full;
  logic                 w_disp;
  logic                 w_ret;
  logic                 w_ret_alu;
  logic                 w_mispred;
  logic [ADDR_W-1:0]    w_redirect;

  assign w_hinfo    = r_info[r_head];
  assign w_hres     = r_res[r_head];
  assign w_full     = (r_count == CNT_W'(ROB_S));
  assign w_disp     = disp_en && !w_full;
  assign w_ret      = (r_count != '0) && r_ready[r_head];
  assign w_ret_alu  = w_ret && !w_hinfo.is_br;
  assign w_mispred  = w_ret && w_hinfo.is_br && (w_hres.taken != w_hinfo.pred);
  assign w_redirect = w_hres.taken ? w_hres.target : ADDR_W'(w_hinfo.pc + ADDR_W'(4));

  // Pointers, ready bits and registered retire/flush outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_ready    <= '0;
      r_reg_we   <= 1'b0;
      r_reg_rd   <= '0;
      r_reg_val  <= '0;
      r_cmt_tag  <= '0;
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
    end else if (rdy) begin
      r_reg_we <= w_ret_alu && (w_hinfo.rd != '0);
      r_flush  <= w_mispred;
      if (w_ret_alu) begin
        r_reg_rd  <= w_hinfo.rd;
        r_reg_val <= w_hres.val;
        r_cmt_tag <= r_head;
      end
      if (w_mispred) begin
        r_flush_pc <= w_redirect;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_ready    <= '0;
      end else begin
        if (w_disp) begin
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + ROB_ADD_W'(1);
        end
        if (w_ret) begin
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + ROB_ADD_W'(1);
        end
        if (cdb_en) r_ready[cdb_tag] <= 1'b1;
        case ({w_disp, w_ret})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry payload storage; meaningless until the matching ready bit is set
  always_ff @(posedge clk) begin
    if (rdy && !w_mispred) begin
      if (w_disp) r_info[r_tail] <= '{rd: disp_rd, is_br: disp_is_br, pred: disp_pred, pc: disp_pc};
      if (cdb_en) r_res[cdb_tag] <= '{val: cdb_val, taken: cdb_taken, target: cdb_target};
    end
  end

  // Operand lookup with same-cycle CDB bypass
  always_comb begin
    qry_rdy = r_ready[qry_tag];
    qry_val = r_res[qry_tag].val;
    if (cdb_en && (cdb_tag == qry_tag)) begin
      qry_rdy = 1'b1;
      qry_val = cdb_val;
    end
  end

  assign disp_tag = r_tail;
  assign full     = w_full;
  assign reg_we   = r_reg_we;
  assign reg_rd   = r_reg_rd;
  assign reg_val  = r_reg_val;
  assign cmt_tag  = r_cmt_tag;
  assign flush    = r_flush;
  assign flush_pc = r_flush_pc;

endmodule
